compound_op_accumulator: RTL

- Execution stage that consumes a stream of (operator, operand) commands and applies each one to an internal WIDTH-bit accumulator. The operator set matches the language's compound assignment set: =, +=, -=, *=, /=, %=, &=, |=, ^=, <<=, >>=, <<<=, >>>=.
- Most operators complete in a single cycle. Divide and modulo run on an iterative restoring divider.
- The result is handed downstream through a valid/ready output; the input side is valid/ready as well.

---
 rtl/compound_op_accumulator.sv | 136 +++++++++++++
 1 files changed

// File: rtl/compound_op_accumulator.sv
// Accumulator execution stage: applies (op, operand) commands to a WIDTH-bit
// accumulator; / and % use a WIDTH-cycle restoring divider, everything else is single cycle.
module compound_op_accumulator #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_operand,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_div_by_zero,
  output logic             o_illegal
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] WVAL = (WIDTH + 1)'(WIDTH);

  typedef enum logic {IDLE, DIV} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  acc, dvd, dvs, rem;
  logic [CW-1:0]     cnt;
  logic              is_mod, out_valid, dbz, ill;
  logic              accept, big;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_dbz, alu_ill, start_div;
  logic [WIDTH:0]    rem_sh, rem_sub;
  logic              ge;
  logic [WIDTH-1:0]  rem_nx, q_nx;

  assign o_in_ready    = !i_rst && !i_clear && (state == IDLE) && (!out_valid || i_out_ready);
  assign accept        = i_in_valid && o_in_ready;
  assign o_out_valid   = out_valid;
  assign o_acc         = acc;
  assign o_div_by_zero = dbz;
  assign o_illegal     = ill;

  // Shift amounts are the full operand; anything >= WIDTH saturates.
  assign big = ({1'b0, i_operand} >= WVAL);

  always_comb begin
    alu_res   = acc;
    alu_dbz   = 1'b0;
    alu_ill   = 1'b0;
    start_div = 1'b0;
    case (i_op)
      4'd0:  alu_res = i_operand;
      4'd1:  alu_res = acc + i_operand;
      4'd2:  alu_res = acc - i_operand;
      4'd3:  alu_res = acc * i_operand;
      4'd4:  if (i_operand == '0) begin alu_res = '1; alu_dbz = 1'b1; end
             else start_div = 1'b1;
      4'd5:  if (i_operand == '0) alu_dbz = 1'b1;
             else start_div = 1'b1;
      4'd6:  alu_res = acc & i_operand;
      4'd7:  alu_res = acc | i_operand;
      4'd8:  alu_res = acc ^ i_operand;
      4'd9,
      4'd11: alu_res = big ? '0 : (acc << i_operand);
      4'd10: alu_res = big ? '0 : (acc >> i_operand);
      4'd12: alu_res = big ? {WIDTH{acc[WIDTH-1]}} : $unsigned($signed(acc) >>> i_operand);
      default: alu_ill = 1'b1;
    endcase
  end

  // One restoring step: quotient bits shift into dvd as the dividend shifts out.
  always_comb begin
    rem_sh  = {rem, dvd[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, dvs};
    ge      = (rem_sh >= {1'b0, dvs});
    rem_nx  = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    q_nx    = {dvd[WIDTH-2:0], ge};
  end

  always_comb begin
    state_nxt = state;
    if (i_clear) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (accept && start_div) state_nxt = DIV;
        DIV:     if (cnt == CW'(1)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc <= '0; dvd <= '0; dvs <= '0; rem <= '0; cnt <= '0;
      is_mod <= 1'b0; out_valid <= 1'b0; dbz <= 1'b0; ill <= 1'b0;
    end else if (i_clear) begin
      acc <= '0; cnt <= '0;
      out_valid <= 1'b0; dbz <= 1'b0; ill <= 1'b0;
    end else begin
      if (out_valid && i_out_ready) begin
        out_valid <= 1'b0; dbz <= 1'b0; ill <= 1'b0;
      end
      if (accept) begin
        if (start_div) begin
          dvd    <= acc;
          dvs    <= i_operand;
          rem    <= '0;
          cnt    <= CW'(WIDTH);
          is_mod <= (i_op == 4'd5);
        end else begin
          acc       <= alu_res;
          out_valid <= 1'b1;
          dbz       <= alu_dbz;
          ill       <= alu_ill;
        end
      end
      if (state == DIV) begin
        dvd <= q_nx;
        rem <= rem_nx;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          acc       <= is_mod ? rem_nx : q_nx;
          out_valid <= 1'b1;
          dbz       <= 1'b0;
          ill       <= 1'b0;
        end
      end
    end
  end

endmodule
